// File: rtl/caliptra_apb_arb_pkg.sv
// Shared types and default sizing for the Caliptra APB round-robin arbiter.
package caliptra_apb_arb_pkg;

   localparam int unsigned DEFAULT_NUM_REQ        = 4;
   localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 256;

   typedef enum logic [1:0] {
      ARB_IDLE   = 2'd0,
      ARB_SETUP  = 2'd1,
      ARB_ACCESS = 2'd2
   } arb_state_e;

endpackage

// File: rtl/caliptra_rr_picker.sv
// Combinational round-robin picker: first asserted request at or after i_ptr,
// wrapping modulo NUM_REQ.
module caliptra_rr_picker
   import caliptra_apb_arb_pkg::*;
#(
   parameter int unsigned NUM_REQ = DEFAULT_NUM_REQ
) (
   input  logic [NUM_REQ-1:0]         i_req,
   input  logic [$clog2(NUM_REQ)-1:0] i_ptr,
   output logic [$clog2(NUM_REQ)-1:0] o_idx,
   output logic                       o_valid
);

   localparam int unsigned IDX_W = $clog2(NUM_REQ);

   always_comb begin
      int unsigned k;
      o_idx   = '0;
      o_valid = 1'b0;
      k       = 0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         k = (32'(i_ptr) + i) % NUM_REQ;
         if (!o_valid && i_req[IDX_W'(k)]) begin
            o_valid = 1'b1;
            o_idx   = IDX_W'(k);
         end
      end
   end

endmodule

// File: rtl/caliptra_apb_rr_arb.sv
// N-to-1 APB round-robin arbiter. Define CALIPTRA_APB_ARB_TIMEOUT_EN to force
// completion (pslverr=1) after TIMEOUT_CYCLES ACCESS cycles without pready.
module caliptra_apb_rr_arb
   import caliptra_apb_arb_pkg::*;
#(
   parameter int unsigned NUM_REQ        = DEFAULT_NUM_REQ,
   parameter int unsigned APB_ADDR_WIDTH = 32,
   parameter int unsigned APB_DATA_WIDTH = 32,
   parameter int unsigned APB_STRB_WIDTH = 4,
   parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
   input  logic                                     i_clk,
   input  logic                                     i_resetn,
   input  logic [NUM_REQ-1:0][APB_ADDR_WIDTH-1:0]   i_apb_req_paddr,
   input  logic [NUM_REQ-1:0][2:0]                  i_apb_req_pprot,
   input  logic [NUM_REQ-1:0]                       i_apb_req_psel,
   input  logic [NUM_REQ-1:0]                       i_apb_req_penable,
   input  logic [NUM_REQ-1:0]                       i_apb_req_pwrite,
   input  logic [NUM_REQ-1:0][APB_DATA_WIDTH-1:0]   i_apb_req_pwdata,
   input  logic [NUM_REQ-1:0][APB_STRB_WIDTH-1:0]   i_apb_req_pstrb,
   input  logic [NUM_REQ-1:0][31:0]                 i_apb_req_pauser,
   output logic [NUM_REQ-1:0]                       o_apb_req_pready,
   output logic [NUM_REQ-1:0]                       o_apb_req_pslverr,
   output logic [NUM_REQ-1:0][APB_DATA_WIDTH-1:0]   o_apb_req_prdata,
   output logic [APB_ADDR_WIDTH-1:0]                o_apb_paddr,
   output logic [2:0]                               o_apb_pprot,
   output logic                                     o_apb_psel,
   output logic                                     o_apb_penable,
   output logic                                     o_apb_pwrite,
   output logic [APB_DATA_WIDTH-1:0]                o_apb_pwdata,
   output logic [APB_STRB_WIDTH-1:0]                o_apb_pstrb,
   output logic [31:0]                              o_apb_pauser,
   input  logic                                     i_apb_pready,
   input  logic                                     i_apb_pslverr,
   input  logic [APB_DATA_WIDTH-1:0]                i_apb_prdata,
   output logic [$clog2(NUM_REQ)-1:0]               o_grant_id
);

   localparam int unsigned    IDX_W    = $clog2(NUM_REQ);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);

   if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 2) begin : g_bad_params
      $error("caliptra_apb_rr_arb: NUM_REQ must be 2..8 and TIMEOUT_CYCLES >= 2");
   end

   arb_state_e       state_q, state_d;
   logic [IDX_W-1:0] grant_q, grant_d;
   logic [IDX_W-1:0] ptr_q, ptr_d, ptr_next;
   logic [IDX_W-1:0] pick_idx;
   logic             pick_valid;
   logic             active;

   // Requester penable is redundant: the arbiter sequences its own phases.
   logic unused_req_penable;
   assign unused_req_penable = ^i_apb_req_penable;

   caliptra_rr_picker #(
      .NUM_REQ (NUM_REQ)
   ) u_picker (
      .i_req   (i_apb_req_psel),
      .i_ptr   (ptr_q),
      .o_idx   (pick_idx),
      .o_valid (pick_valid)
   );

   assign ptr_next = (grant_q == LAST_IDX) ? '0 : grant_q + IDX_W'(1);

`ifdef CALIPTRA_APB_ARB_TIMEOUT_EN
   localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES);
   logic [TO_W-1:0] to_cnt_q;
   logic            to_hit;

   assign to_hit = (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge i_clk or negedge i_resetn) begin
      if (!i_resetn) begin
         to_cnt_q <= '0;
      end else if (state_q == ARB_ACCESS && state_d == ARB_ACCESS) begin
         to_cnt_q <= to_cnt_q + TO_W'(1);
      end else begin
         to_cnt_q <= '0;
      end
   end
`endif

   always_ff @(posedge i_clk or negedge i_resetn) begin
      if (!i_resetn) begin
         state_q <= ARB_IDLE;
         grant_q <= '0;
         ptr_q   <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         ptr_q   <= ptr_d;
      end
   end

   always_comb begin
      state_d           = state_q;
      grant_d           = grant_q;
      ptr_d             = ptr_q;
      o_apb_psel        = 1'b0;
      o_apb_penable     = 1'b0;
      o_apb_req_pready  = '0;
      o_apb_req_pslverr = '0;
      o_apb_req_prdata  = '0;
      unique case (state_q)
         ARB_IDLE: begin
            if (pick_valid) begin
               grant_d = pick_idx;
               state_d = ARB_SETUP;
            end
         end
         ARB_SETUP: begin
            o_apb_psel = 1'b1;
            state_d    = ARB_ACCESS;
         end
         ARB_ACCESS: begin
            o_apb_psel    = 1'b1;
            o_apb_penable = 1'b1;
            if (i_apb_pready) begin
               o_apb_req_pready[grant_q]  = 1'b1;
               o_apb_req_pslverr[grant_q] = i_apb_pslverr;
               o_apb_req_prdata[grant_q]  = i_apb_prdata;
               ptr_d                      = ptr_next;
               state_d                    = ARB_IDLE;
            end
`ifdef CALIPTRA_APB_ARB_TIMEOUT_EN
            else if (to_hit) begin
               o_apb_psel                 = 1'b0;
               o_apb_penable              = 1'b0;
               o_apb_req_pready[grant_q]  = 1'b1;
               o_apb_req_pslverr[grant_q] = 1'b1;
               ptr_d                      = ptr_next;
               state_d                    = ARB_IDLE;
            end
`endif
         end
         default: state_d = ARB_IDLE;
      endcase
   end

   // Payload follows the grant in SETUP/ACCESS and is held at zero in IDLE.
   assign active       = (state_q != ARB_IDLE);
   assign o_apb_paddr  = active ? i_apb_req_paddr[grant_q]  : '0;
   assign o_apb_pprot  = active ? i_apb_req_pprot[grant_q]  : '0;
   assign o_apb_pwrite = active ? i_apb_req_pwrite[grant_q] : 1'b0;
   assign o_apb_pwdata = active ? i_apb_req_pwdata[grant_q] : '0;
   assign o_apb_pstrb  = active ? i_apb_req_pstrb[grant_q]  : '0;
   assign o_apb_pauser = active ? i_apb_req_pauser[grant_q] : '0;
   assign o_grant_id   = grant_q;

endmodule

// File: tb/tb_caliptra_apb_rr_arb.sv
// Directed self-checking bench for caliptra_apb_rr_arb (4 requesters,
// TIMEOUT_CYCLES=16; timeout scenario follows CALIPTRA_APB_ARB_TIMEOUT_EN).
module tb_caliptra_apb_rr_arb;

   localparam int NR = 4;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int SW = 4;

   logic                   i_clk = 1'b0;
   logic                   i_resetn = 1'b0;
   logic [NR-1:0][AW-1:0]  i_apb_req_paddr;
   logic [NR-1:0][2:0]     i_apb_req_pprot;
   logic [NR-1:0]          i_apb_req_psel;
   logic [NR-1:0]          i_apb_req_penable;
   logic [NR-1:0]          i_apb_req_pwrite;
   logic [NR-1:0][DW-1:0]  i_apb_req_pwdata;
   logic [NR-1:0][SW-1:0]  i_apb_req_pstrb;
   logic [NR-1:0][31:0]    i_apb_req_pauser;
   logic [NR-1:0]          o_apb_req_pready;
   logic [NR-1:0]          o_apb_req_pslverr;
   logic [NR-1:0][DW-1:0]  o_apb_req_prdata;
   logic [AW-1:0]          o_apb_paddr;
   logic [2:0]             o_apb_pprot;
   logic                   o_apb_psel;
   logic                   o_apb_penable;
   logic                   o_apb_pwrite;
   logic [DW-1:0]          o_apb_pwdata;
   logic [SW-1:0]          o_apb_pstrb;
   logic [31:0]            o_apb_pauser;
   logic                   i_apb_pready;
   logic                   i_apb_pslverr;
   logic [DW-1:0]          i_apb_prdata;
   logic [1:0]             o_grant_id;

   int checks = 0;
   int errors = 0;
   logic [NR-1:0][DW-1:0] exp_rd;

   caliptra_apb_rr_arb #(
      .NUM_REQ        (NR),
      .APB_ADDR_WIDTH (AW),
      .APB_DATA_WIDTH (DW),
      .APB_STRB_WIDTH (SW),
      .TIMEOUT_CYCLES (16)
   ) dut (
      .i_clk             (i_clk),
      .i_resetn          (i_resetn),
      .i_apb_req_paddr   (i_apb_req_paddr),
      .i_apb_req_pprot   (i_apb_req_pprot),
      .i_apb_req_psel    (i_apb_req_psel),
      .i_apb_req_penable (i_apb_req_penable),
      .i_apb_req_pwrite  (i_apb_req_pwrite),
      .i_apb_req_pwdata  (i_apb_req_pwdata),
      .i_apb_req_pstrb   (i_apb_req_pstrb),
      .i_apb_req_pauser  (i_apb_req_pauser),
      .o_apb_req_pready  (o_apb_req_pready),
      .o_apb_req_pslverr (o_apb_req_pslverr),
      .o_apb_req_prdata  (o_apb_req_prdata),
      .o_apb_paddr       (o_apb_paddr),
      .o_apb_pprot       (o_apb_pprot),
      .o_apb_psel        (o_apb_psel),
      .o_apb_penable     (o_apb_penable),
      .o_apb_pwrite      (o_apb_pwrite),
      .o_apb_pwdata      (o_apb_pwdata),
      .o_apb_pstrb       (o_apb_pstrb),
      .o_apb_pauser      (o_apb_pauser),
      .i_apb_pready      (i_apb_pready),
      .i_apb_pslverr     (i_apb_pslverr),
      .i_apb_prdata      (i_apb_prdata),
      .o_grant_id        (o_grant_id)
   );

   always #5 i_clk = ~i_clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
      $fatal(1, "watchdog expired");
   end

   task automatic tick;
      @(negedge i_clk);
   endtask

   task automatic init_inputs;
      for (int i = 0; i < NR; i++) begin
         i_apb_req_paddr[i]  = 32'h4000_0000 + 32'(i) * 32'h10;
         i_apb_req_pprot[i]  = 3'(i + 1);
         i_apb_req_pwrite[i] = (i % 2) == 1;
         i_apb_req_pwdata[i] = 32'h1111_0000 + 32'(i);
         i_apb_req_pstrb[i]  = 4'(4'hF - i);
         i_apb_req_pauser[i] = 32'hC0DE_0000 + 32'(i);
      end
      i_apb_req_psel    = '0;
      i_apb_req_penable = '0;
      i_apb_pready      = 1'b0;
      i_apb_pslverr     = 1'b0;
      i_apb_prdata      = '0;
   endtask

   task automatic do_reset;
      i_resetn = 1'b0;
      init_inputs();
      tick();
      tick();
      #1;
      i_resetn = 1'b1;
   endtask

   task automatic test_reset;
      i_resetn = 1'b0;
      init_inputs();
      i_apb_req_psel = 4'hF;
      i_apb_pready   = 1'b1;
      i_apb_pslverr  = 1'b1;
      i_apb_prdata   = 32'hFFFF_FFFF;
      tick();
      tick();
      #1;
      checks++;
      if ({o_apb_req_pready, o_apb_req_pslverr, o_apb_req_prdata, o_apb_paddr, o_apb_pprot,
           o_apb_psel, o_apb_penable, o_apb_pwrite, o_apb_pwdata, o_apb_pstrb, o_apb_pauser} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: got psel=%b pready=%b prdata=%h paddr=%h, required all zero",
                  o_apb_psel, o_apb_req_pready, o_apb_req_prdata, o_apb_paddr);
      end
      checks++;
      if (o_grant_id !== 2'd0) begin
         errors++;
         $display("FAIL reset_grant: got %0d required 0", o_grant_id);
      end
   endtask

   task automatic test_single;
      do_reset();
      i_apb_req_psel = 4'b0100;
      i_apb_pready   = 1'b1;
      #1;
      checks++;
      if (o_apb_psel !== 1'b0 || o_apb_req_pready !== 4'b0000 || o_apb_paddr !== 32'h0) begin
         errors++;
         $display("FAIL single_idle: got psel=%b pready=%b paddr=%h required 0/0000/0",
                  o_apb_psel, o_apb_req_pready, o_apb_paddr);
      end
      tick();
      #1;
      checks++;
      if (o_apb_psel !== 1'b1 || o_apb_penable !== 1'b0 || o_grant_id !== 2'd2) begin
         errors++;
         $display("FAIL single_setup: got psel=%b penable=%b grant=%0d required 1/0/2",
                  o_apb_psel, o_apb_penable, o_grant_id);
      end
      checks++;
      if (o_apb_paddr !== 32'h4000_0020 || o_apb_pauser !== 32'hC0DE_0002 || o_apb_pprot !== 3'd3 ||
          o_apb_pwrite !== 1'b0 || o_apb_pstrb !== 4'hD || o_apb_pwdata !== 32'h1111_0002) begin
         errors++;
         $display("FAIL single_mux: got paddr=%h pauser=%h pprot=%0d pwrite=%b pstrb=%h pwdata=%h required 40000020/c0de0002/3/0/d/11110002",
                  o_apb_paddr, o_apb_pauser, o_apb_pprot, o_apb_pwrite, o_apb_pstrb, o_apb_pwdata);
      end
      checks++;
      if (o_apb_req_pready !== 4'b0000) begin
         errors++;
         $display("FAIL single_setup_pready: got %b required 0000", o_apb_req_pready);
      end
      tick();
      #1;
      checks++;
      if (o_apb_psel !== 1'b1 || o_apb_penable !== 1'b1 || o_apb_req_pready !== 4'b0100 || o_grant_id !== 2'd2) begin
         errors++;
         $display("FAIL single_access: got psel=%b penable=%b pready=%b grant=%0d required 1/1/0100/2",
                  o_apb_psel, o_apb_penable, o_apb_req_pready, o_grant_id);
      end
      i_apb_req_psel = '0;
      tick();
      #1;
      checks++;
      if (o_apb_psel !== 1'b0 || o_apb_paddr !== 32'h0 || o_grant_id !== 2'd2) begin
         errors++;
         $display("FAIL single_return_idle: got psel=%b paddr=%h grant=%0d required 0/0/2",
                  o_apb_psel, o_apb_paddr, o_grant_id);
      end
   endtask

   task automatic test_round_robin;
      do_reset();
      i_apb_req_psel = 4'hF;
      i_apb_pready   = 1'b1;
      for (int k = 0; k < 5; k++) begin
         int e;
         e = k % NR;
         #1;
         checks++;
         if (o_apb_psel !== 1'b0) begin
            errors++;
            $display("FAIL rr_idle[%0d]: got psel=%b required 0", k, o_apb_psel);
         end
         tick();
         #1;
         checks++;
         if (o_grant_id !== 2'(e) || o_apb_pwdata !== 32'h1111_0000 + 32'(e)) begin
            errors++;
            $display("FAIL rr_grant[%0d]: got grant=%0d pwdata=%h required %0d/%h",
                     k, o_grant_id, o_apb_pwdata, e, 32'h1111_0000 + 32'(e));
         end
         tick();
         i_apb_prdata = 32'hA0 + 32'(e);
         exp_rd = '0;
         exp_rd[e] = 32'hA0 + 32'(e);
         #1;
         checks++;
         if (o_apb_req_pready !== 4'(1 << e) || o_apb_req_prdata !== exp_rd || o_apb_req_pslverr !== 4'b0000) begin
            errors++;
            $display("FAIL rr_complete[%0d]: got pready=%b prdata=%h pslverr=%b required %b/%h/0000",
                     k, o_apb_req_pready, o_apb_req_prdata, o_apb_req_pslverr, 4'(1 << e), exp_rd);
         end
         tick();
      end
      i_apb_req_psel = '0;
      i_apb_prdata   = '0;
      tick();
   endtask

   task automatic test_wait_states;
      do_reset();
      i_apb_req_psel = 4'b1010;
      i_apb_pready   = 1'b0;
      #1;
      tick();
      #1;
      checks++;
      if (o_grant_id !== 2'd1 || o_apb_pwrite !== 1'b1) begin
         errors++;
         $display("FAIL wait_grant: got grant=%0d pwrite=%b required 1/1", o_grant_id, o_apb_pwrite);
      end
      tick();
      for (int w = 0; w < 5; w++) begin
         #1;
         checks++;
         if (o_apb_penable !== 1'b1 || o_apb_req_pready !== 4'b0000 || o_apb_req_prdata !== '0) begin
            errors++;
            $display("FAIL wait_hold[%0d]: got penable=%b pready=%b prdata=%h required 1/0000/0",
                     w, o_apb_penable, o_apb_req_pready, o_apb_req_prdata);
         end
         tick();
      end
      i_apb_pready  = 1'b1;
      i_apb_pslverr = 1'b1;
      i_apb_prdata  = 32'hDEAD_BEEF;
      exp_rd        = '0;
      exp_rd[1]     = 32'hDEAD_BEEF;
      #1;
      checks++;
      if (o_apb_req_pready !== 4'b0010 || o_apb_req_pslverr !== 4'b0010 || o_apb_req_prdata !== exp_rd) begin
         errors++;
         $display("FAIL wait_complete: got pready=%b pslverr=%b prdata=%h required 0010/0010/%h",
                  o_apb_req_pready, o_apb_req_pslverr, o_apb_req_prdata, exp_rd);
      end
      tick();
      i_apb_pready   = 1'b0;
      i_apb_pslverr  = 1'b0;
      i_apb_prdata   = '0;
      i_apb_req_psel = 4'b1000;
      #1;
      tick();
      #1;
      checks++;
      if (o_grant_id !== 2'd3) begin
         errors++;
         $display("FAIL wait_next_grant: got %0d required 3", o_grant_id);
      end
      i_apb_req_psel = '0;
      tick();
      i_apb_pready = 1'b1;
      #1;
      checks++;
      if (o_apb_req_pready !== 4'b1000) begin
         errors++;
         $display("FAIL wait_next_complete: got %b required 1000", o_apb_req_pready);
      end
      tick();
      i_apb_pready = 1'b0;
   endtask

   task automatic test_timeout;
      do_reset();
      i_apb_req_psel = 4'b0001;
      i_apb_pready   = 1'b0;
      #1;
      tick();
      tick();
`ifdef CALIPTRA_APB_ARB_TIMEOUT_EN
      for (int c = 1; c < 16; c++) begin
         #1;
         checks++;
         if (o_apb_psel !== 1'b1 || o_apb_req_pready !== 4'b0000) begin
            errors++;
            $display("FAIL timeout_wait[%0d]: got psel=%b pready=%b required 1/0000", c, o_apb_psel, o_apb_req_pready);
         end
         tick();
      end
      #1;
      checks++;
      if (o_apb_req_pready !== 4'b0001 || o_apb_req_pslverr !== 4'b0001 || o_apb_req_prdata !== '0 ||
          o_apb_psel !== 1'b0) begin
         errors++;
         $display("FAIL timeout_fire: got pready=%b pslverr=%b prdata=%h psel=%b required 0001/0001/0/0",
                  o_apb_req_pready, o_apb_req_pslverr, o_apb_req_prdata, o_apb_psel);
      end
      i_apb_req_psel = '0;
      tick();
      i_apb_pready = 1'b1;
      #1;
      checks++;
      if (o_apb_psel !== 1'b0 || o_apb_req_pready !== 4'b0000) begin
         errors++;
         $display("FAIL timeout_late_pready: got psel=%b pready=%b required 0/0000", o_apb_psel, o_apb_req_pready);
      end
      tick();
      i_apb_pready = 1'b0;
`else
      for (int c = 1; c <= 30; c++) begin
         #1;
         checks++;
         if (o_apb_psel !== 1'b1 || o_apb_penable !== 1'b1 || o_apb_req_pready !== 4'b0000) begin
            errors++;
            $display("FAIL no_timeout_wait[%0d]: got psel=%b penable=%b pready=%b required 1/1/0000",
                     c, o_apb_psel, o_apb_penable, o_apb_req_pready);
         end
         tick();
      end
      i_apb_pready = 1'b1;
      #1;
      checks++;
      if (o_apb_req_pready !== 4'b0001 || o_apb_req_pslverr !== 4'b0000) begin
         errors++;
         $display("FAIL no_timeout_complete: got pready=%b pslverr=%b required 0001/0000",
                  o_apb_req_pready, o_apb_req_pslverr);
      end
      i_apb_req_psel = '0;
      tick();
      i_apb_pready = 1'b0;
`endif
   endtask

   task automatic test_reset_mid;
      do_reset();
      i_apb_req_psel = 4'b0100;
      i_apb_pready   = 1'b1;
      #1;
      tick();
      tick();
      #1;
      checks++;
      if (o_apb_req_pready !== 4'b0100) begin
         errors++;
         $display("FAIL rstmid_first: got pready=%b required 0100", o_apb_req_pready);
      end
      tick();
      tick();
      i_apb_pready = 1'b0;
      tick();
      #2;
      i_resetn = 1'b0;
      #1;
      checks++;
      if ({o_apb_req_pready, o_apb_req_pslverr, o_apb_req_prdata, o_apb_paddr, o_apb_pprot,
           o_apb_psel, o_apb_penable, o_apb_pwrite, o_apb_pwdata, o_apb_pstrb, o_apb_pauser} !== '0 ||
          o_grant_id !== 2'd0) begin
         errors++;
         $display("FAIL rstmid_outputs: got psel=%b penable=%b paddr=%h grant=%0d required all zero",
                  o_apb_psel, o_apb_penable, o_apb_paddr, o_grant_id);
      end
      tick();
      tick();
      i_apb_req_psel = 4'b1001;
      i_apb_pready   = 1'b1;
      #1;
      i_resetn = 1'b1;
      #1;
      checks++;
      if (o_apb_psel !== 1'b0 || o_apb_req_pready !== 4'b0000) begin
         errors++;
         $display("FAIL rstmid_release: got psel=%b pready=%b required 0/0000", o_apb_psel, o_apb_req_pready);
      end
      tick();
      #1;
      checks++;
      if (o_grant_id !== 2'd0 || o_apb_psel !== 1'b1) begin
         errors++;
         $display("FAIL rstmid_regrant: got grant=%0d psel=%b required 0/1", o_grant_id, o_apb_psel);
      end
      i_apb_req_psel = '0;
      tick();
      #1;
      checks++;
      if (o_apb_req_pready !== 4'b0001) begin
         errors++;
         $display("FAIL rstmid_complete: got %b required 0001", o_apb_req_pready);
      end
      tick();
      i_apb_pready = 1'b0;
   endtask

   task automatic test_drop_psel;
      do_reset();
      i_apb_req_psel = 4'b0010;
      i_apb_pready   = 1'b1;
      #1;
      tick();
      i_apb_req_psel = '0;
      #1;
      checks++;
      if (o_apb_psel !== 1'b1 || o_apb_penable !== 1'b0 || o_grant_id !== 2'd1) begin
         errors++;
         $display("FAIL drop_setup: got psel=%b penable=%b grant=%0d required 1/0/1",
                  o_apb_psel, o_apb_penable, o_grant_id);
      end
      tick();
      #1;
      checks++;
      if (o_apb_req_pready !== 4'b0010 || o_apb_penable !== 1'b1) begin
         errors++;
         $display("FAIL drop_complete: got pready=%b penable=%b required 0010/1", o_apb_req_pready, o_apb_penable);
      end
      i_apb_req_psel = 4'b0110;
      tick();
      #1;
      checks++;
      if (o_apb_psel !== 1'b0) begin
         errors++;
         $display("FAIL drop_idle: got psel=%b required 0", o_apb_psel);
      end
      tick();
      #1;
      checks++;
      if (o_grant_id !== 2'd2) begin
         errors++;
         $display("FAIL drop_ptr_advance: got grant=%0d required 2", o_grant_id);
      end
      i_apb_req_psel = '0;
      tick();
      tick();
      i_apb_pready = 1'b0;
   endtask

   initial begin
      init_inputs();
      test_reset();
      test_single();
      test_round_robin();
      test_wait_states();
      test_timeout();
      test_reset_mid();
      test_drop_psel();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
